vec_lane_sequencer: RTL and testbench

//  Multi-cycle controller between DE and the EX-stage scalar ALU. Accepts one

---
 rtl/vec_lane_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_vec_lane_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_lane_sequencer.sv
// ---------------------------------------------------------------------------
// vec_lane_sequencer
// Runs one vector op from DE through the shared scalar ALU, one lane per
// cycle, and presents the assembled result vector to MEM.
// All state updates on the falling edge of I_CLOCK; I_RESETN is async low.
//
// Ports
//   I_CLOCK, I_RESETN       clock (negedge active), async active-low reset
//   I_Valid / O_Ready       DE handshake; O_Ready is high only in IDLE
//   I_VecOp                 00 VADD, 01 VMOV, 10 VMOVI, 11 VCOMPMOVI
//   I_VecSrc1/2Value        source vectors, lane k = bits[LW*k +: LW]
//   I_Imm, I_Idx            immediate and VCOMPMOVI target lane
//   I_DestVRegIdx           destination vector register
//   O_AluA/B/Op, I_AluResult  shared ALU (result is same-cycle combinational)
//   O_StallSignal           holds DE while an op is in flight
//   I_GPUStallSignal        downstream stall while the result is presented
//   O_EX_Valid, O_VRegWEn   result valid / register write enable
//   O_DestVRegIdx, O_VecDestValue  registered result index and vector
// ---------------------------------------------------------------------------
module vec_lane_sequencer #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned LANE_WIDTH = 16,
    parameter int unsigned VID_WIDTH  = 6
) (
    input  logic                          I_CLOCK,
    input  logic                          I_RESETN,
    input  logic                          I_Valid,
    output logic                          O_Ready,
    input  logic [1:0]                    I_VecOp,
    input  logic [LANES*LANE_WIDTH-1:0]   I_VecSrc1Value,
    input  logic [LANES*LANE_WIDTH-1:0]   I_VecSrc2Value,
    input  logic [LANE_WIDTH-1:0]         I_Imm,
    input  logic [1:0]                    I_Idx,
    input  logic [VID_WIDTH-1:0]          I_DestVRegIdx,
    output logic [LANE_WIDTH-1:0]         O_AluA,
    output logic [LANE_WIDTH-1:0]         O_AluB,
    output logic [1:0]                    O_AluOp,
    input  logic [LANE_WIDTH-1:0]         I_AluResult,
    output logic                          O_StallSignal,
    input  logic                          I_GPUStallSignal,
    output logic                          O_EX_Valid,
    output logic                          O_VRegWEn,
    output logic [VID_WIDTH-1:0]          O_DestVRegIdx,
    output logic [LANES*LANE_WIDTH-1:0]   O_VecDestValue
);

    localparam int unsigned LW    = LANE_WIDTH;
    localparam int unsigned VW    = LANES * LANE_WIDTH;
    localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned DRV_W = 2 + 2 * LANE_WIDTH;

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    localparam logic [1:0] OP_VADD  = 2'b00;
    localparam logic [1:0] OP_VMOV  = 2'b01;
    localparam logic [1:0] OP_VMOVI = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_PASS_A = 2'b01;
    localparam logic [1:0] ALU_PASS_B = 2'b10;

    // ALU drive packed as {op, a, b}; idle drive is PASS_A with zero operands
    localparam logic [DRV_W-1:0] DRV_IDLE = {ALU_PASS_A, {(2 * LANE_WIDTH){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [1:0]           op_q, op_d;
    logic [VW-1:0]        src1_q, src1_d;
    logic [VW-1:0]        src2_q, src2_d;
    logic [LW-1:0]        imm_q, imm_d;
    logic [1:0]           idx_q, idx_d;
    logic [VID_WIDTH-1:0] dest_q, dest_d;
    logic [VW-1:0]        acc_q, acc_d;
    logic                 valid_q, valid_d;
    logic [VID_WIDTH-1:0] out_idx_q, out_idx_d;
    logic [VW-1:0]        out_vec_q, out_vec_d;
    logic [DRV_W-1:0]     drv_q, drv_d;

    // ALU operands/op for one lane of a vector op
    function automatic logic [DRV_W-1:0] lane_drive(
        input logic [1:0]       op,
        input logic [VW-1:0]    src1,
        input logic [VW-1:0]    src2,
        input logic [LW-1:0]    imm,
        input logic [1:0]       idx,
        input logic [CNT_W-1:0] lane
    );
        logic [LW-1:0] a_lane;
        logic [LW-1:0] b_lane;
        logic [1:0]    alu_op;
        logic [LW-1:0] drv_a;
        logic [LW-1:0] drv_b;
        a_lane = src1[int'(lane) * LW +: LW];
        b_lane = src2[int'(lane) * LW +: LW];
        alu_op = ALU_PASS_A;
        drv_a  = '0;
        drv_b  = '0;
        case (op)
            OP_VADD: begin
                alu_op = ALU_ADD;
                drv_a  = a_lane;
                drv_b  = b_lane;
            end
            OP_VMOV: begin
                alu_op = ALU_PASS_A;
                drv_a  = a_lane;
            end
            OP_VMOVI: begin
                alu_op = ALU_PASS_B;
                drv_b  = imm;
            end
            default: begin
                // VCOMPMOVI: immediate into the selected lane, src1 elsewhere
                if (int'(lane) == int'(idx)) begin
                    alu_op = ALU_PASS_B;
                    drv_b  = imm;
                end else begin
                    alu_op = ALU_PASS_A;
                    drv_a  = a_lane;
                end
            end
        endcase
        return {alu_op, drv_a, drv_b};
    endfunction

    assign cnt_nxt = cnt_q + CNT_W'(1);

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        imm_d     = imm_q;
        idx_d     = idx_q;
        dest_d    = dest_q;
        acc_d     = acc_q;
        valid_d   = valid_q;
        out_idx_d = out_idx_q;
        out_vec_d = out_vec_q;
        drv_d     = DRV_IDLE;

        case (state_q)
            S_IDLE: begin
                if (I_Valid) begin
                    op_d    = I_VecOp;
                    src1_d  = I_VecSrc1Value;
                    src2_d  = I_VecSrc2Value;
                    imm_d   = I_Imm;
                    idx_d   = I_Idx;
                    dest_d  = I_DestVRegIdx;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    // ALU drive is registered, so lane 0 is prepared on accept
                    drv_d   = lane_drive(I_VecOp, I_VecSrc1Value, I_VecSrc2Value,
                                         I_Imm, I_Idx, '0);
                end
            end
            S_RUN: begin
                acc_d[int'(cnt_q) * LW +: LW] = I_AluResult;
                if (cnt_q == LAST_LANE) begin
                    state_d   = S_DONE;
                    valid_d   = 1'b1;
                    out_vec_d = acc_d;
                    out_idx_d = dest_q;
                end else begin
                    cnt_d = cnt_nxt;
                    drv_d = lane_drive(op_q, src1_q, src2_q, imm_q, idx_q, cnt_nxt);
                end
            end
            S_DONE: begin
                if (!I_GPUStallSignal) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(negedge I_CLOCK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            imm_q     <= '0;
            idx_q     <= '0;
            dest_q    <= '0;
            acc_q     <= '0;
            valid_q   <= 1'b0;
            out_idx_q <= '0;
            out_vec_q <= '0;
            drv_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            imm_q     <= imm_d;
            idx_q     <= idx_d;
            dest_q    <= dest_d;
            acc_q     <= acc_d;
            valid_q   <= valid_d;
            out_idx_q <= out_idx_d;
            out_vec_q <= out_vec_d;
            drv_q     <= drv_d;
        end
    end

    assign O_Ready        = (state_q == S_IDLE);
    assign O_StallSignal  = (state_q != S_IDLE);
    assign O_EX_Valid     = valid_q;
    assign O_VRegWEn      = valid_q;
    assign O_DestVRegIdx  = out_idx_q;
    assign O_VecDestValue = out_vec_q;
    assign O_AluOp        = drv_q[DRV_W-1 -: 2];
    assign O_AluA         = drv_q[2*LW-1 -: LW];
    assign O_AluB         = drv_q[LW-1:0];

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vec_lane_sequencer
// Scoreboard bench: the stimulus pushes the expected result vector and index
// for every op it issues; a monitor pops and compares whenever the DUT
// presents a valid result. DUT state changes on negedge, so the monitor
// samples on posedge and the stimulus drives 1 time unit after negedge.
// ---------------------------------------------------------------------------
module tb_vec_lane_sequencer;

    localparam int unsigned LANES = 4;
    localparam int unsigned LW    = 16;
    localparam int unsigned VW    = LANES * LW;
    localparam int unsigned VIDW  = 6;

    logic            I_CLOCK;
    logic            I_RESETN;
    logic            I_Valid;
    logic            O_Ready;
    logic [1:0]      I_VecOp;
    logic [VW-1:0]   I_VecSrc1Value;
    logic [VW-1:0]   I_VecSrc2Value;
    logic [LW-1:0]   I_Imm;
    logic [1:0]      I_Idx;
    logic [VIDW-1:0] I_DestVRegIdx;
    logic [LW-1:0]   O_AluA;
    logic [LW-1:0]   O_AluB;
    logic [1:0]      O_AluOp;
    logic [LW-1:0]   I_AluResult;
    logic            O_StallSignal;
    logic            I_GPUStallSignal;
    logic            O_EX_Valid;
    logic            O_VRegWEn;
    logic [VIDW-1:0] O_DestVRegIdx;
    logic [VW-1:0]   O_VecDestValue;

    vec_lane_sequencer #(.LANES(LANES), .LANE_WIDTH(LW), .VID_WIDTH(VIDW)) dut (
        .I_CLOCK          (I_CLOCK),
        .I_RESETN         (I_RESETN),
        .I_Valid          (I_Valid),
        .O_Ready          (O_Ready),
        .I_VecOp          (I_VecOp),
        .I_VecSrc1Value   (I_VecSrc1Value),
        .I_VecSrc2Value   (I_VecSrc2Value),
        .I_Imm            (I_Imm),
        .I_Idx            (I_Idx),
        .I_DestVRegIdx    (I_DestVRegIdx),
        .O_AluA           (O_AluA),
        .O_AluB           (O_AluB),
        .O_AluOp          (O_AluOp),
        .I_AluResult      (I_AluResult),
        .O_StallSignal    (O_StallSignal),
        .I_GPUStallSignal (I_GPUStallSignal),
        .O_EX_Valid       (O_EX_Valid),
        .O_VRegWEn        (O_VRegWEn),
        .O_DestVRegIdx    (O_DestVRegIdx),
        .O_VecDestValue   (O_VecDestValue)
    );

    // Scalar ALU of the EX stage: combinational, same cycle
    assign I_AluResult = (O_AluOp == 2'b00) ? LW'(O_AluA + O_AluB) :
                         (O_AluOp == 2'b01) ? O_AluA :
                         (O_AluOp == 2'b10) ? O_AluB : LW'(0);

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    typedef struct packed {
        logic [VW-1:0]   vec;
        logic [VIDW-1:0] idx;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result vector: per-lane from the op definition
    function automatic logic [VW-1:0] ref_vec(input logic [1:0] op, input logic [VW-1:0] s1,
                                              input logic [VW-1:0] s2, input logic [LW-1:0] imm,
                                              input logic [1:0] idx);
        logic [VW-1:0] r;
        logic [LW-1:0] a;
        logic [LW-1:0] b;
        r = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            a = s1[k*LW +: LW];
            b = s2[k*LW +: LW];
            case (op)
                2'b00:   r[k*LW +: LW] = LW'(a + b);
                2'b01:   r[k*LW +: LW] = a;
                2'b10:   r[k*LW +: LW] = imm;
                default: r[k*LW +: LW] = (k == int'(idx)) ? imm : a;
            endcase
        end
        return r;
    endfunction

    // Downstream stall driver: fixed count of stalls on a valid result, or random
    int stall_left = 0;
    bit stall_rand = 1'b0;
    always @(negedge I_CLOCK) begin
        #1;
        if (stall_left > 0 && O_EX_Valid) begin
            I_GPUStallSignal = 1'b1;
            stall_left--;
        end else if (stall_rand) begin
            I_GPUStallSignal = ($urandom_range(0, 2) == 0);
        end else begin
            I_GPUStallSignal = 1'b0;
        end
    end

    // Monitor: handshake timing and scoreboard comparison
    int cyc = 0;
    int acc_cyc = 0;
    bit in_flight = 1'b0;
    bit exit_pend = 1'b0;
    bit prev_valid = 1'b0;
    int vrun = 0;
    int last_len = 0;
    always @(posedge I_CLOCK) begin
        exp_t e;
        cyc++;
        if (!I_RESETN) begin
            chk("rst_valid", 64'(O_EX_Valid), 64'(0));
            chk("rst_vec", 64'(O_VecDestValue), 64'(0));
            chk("rst_aluop", 64'(O_AluOp), 64'(0));
            in_flight  = 1'b0;
            exit_pend  = 1'b0;
            prev_valid = 1'b0;
            vrun       = 0;
        end else begin
            chk("stall_vs_ready", 64'(O_StallSignal), 64'(!O_Ready));
            chk("wen_vs_valid", 64'(O_VRegWEn), 64'(O_EX_Valid));
            if (exit_pend) begin
                chk("ready_after_exit", 64'(O_Ready), 64'(1));
                exit_pend = 1'b0;
                in_flight = 1'b0;
            end else if (in_flight) begin
                chk("ready_while_busy", 64'(O_Ready), 64'(0));
            end
            if (O_EX_Valid) begin
                if (!prev_valid)
                    chk("latency", 64'(cyc), 64'(acc_cyc + int'(LANES) + 1));
                if (sb.size() == 0) begin
                    chk("spurious_valid", 64'(O_EX_Valid), 64'(0));
                end else begin
                    e = sb[0];
                    chk("dest_vec", 64'(O_VecDestValue), 64'(e.vec));
                    chk("dest_idx", 64'(O_DestVRegIdx), 64'(e.idx));
                    vrun++;
                    if (!I_GPUStallSignal) begin
                        void'(sb.pop_front());
                        exit_pend = 1'b1;
                        last_len  = vrun;
                        vrun      = 0;
                    end
                end
            end
            if (O_Ready && I_Valid) begin
                acc_cyc   = cyc;
                in_flight = 1'b1;
            end
            prev_valid = O_EX_Valid;
        end
    end

    // Present an op and hold it until the posedge where the DUT is ready;
    // returns 1 time unit after the accepting negedge with I_Valid still high.
    task automatic issue(input logic [1:0] op, input logic [VW-1:0] s1, input logic [VW-1:0] s2,
                         input logic [LW-1:0] imm, input logic [1:0] idx, input logic [VIDW-1:0] dst);
        exp_t e;
        int   n;
        e.vec = ref_vec(op, s1, s2, imm, idx);
        e.idx = dst;
        sb.push_back(e);
        I_VecOp        = op;
        I_VecSrc1Value = s1;
        I_VecSrc2Value = s2;
        I_Imm          = imm;
        I_Idx          = idx;
        I_DestVRegIdx  = dst;
        I_Valid        = 1'b1;
        n = 0;
        while (1) begin
            @(posedge I_CLOCK);
            if (O_Ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 64'(O_Ready), 64'(1));
                break;
            end
        end
        @(negedge I_CLOCK);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(sb.size() == 0 && O_Ready)) begin
            @(posedge I_CLOCK);
            n++;
            if (n > 300) begin
                chk("drain_timeout", 64'(sb.size()), 64'(0));
                break;
            end
        end
        @(negedge I_CLOCK);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        I_Valid = 1'b0;
        repeat (n) begin
            @(negedge I_CLOCK);
            #1;
        end
    endtask

    initial begin
        I_RESETN         = 1'b0;
        I_Valid          = 1'b0;
        I_VecOp          = '0;
        I_VecSrc1Value   = '0;
        I_VecSrc2Value   = '0;
        I_Imm            = '0;
        I_Idx            = '0;
        I_DestVRegIdx    = '0;
        I_GPUStallSignal = 1'b0;

        // Reset state
        repeat (2) @(posedge I_CLOCK);
        chk("rst_ready", 64'(O_Ready), 64'(1));
        chk("rst_stall", 64'(O_StallSignal), 64'(0));
        chk("rst_idx", 64'(O_DestVRegIdx), 64'(0));
        chk("rst_alua", 64'(O_AluA), 64'(0));
        chk("rst_alub", 64'(O_AluB), 64'(0));
        chk("rst_wen", 64'(O_VRegWEn), 64'(0));
        @(negedge I_CLOCK);
        #1;
        I_RESETN = 1'b1;
        @(negedge I_CLOCK);
        #1;
        chk("idle_aluop", 64'(O_AluOp), 64'(2'b01));

        // 1: VADD basic
        issue(2'b00, 64'h0004_0003_0002_0001, 64'h0010_0010_0010_0010, 16'h0, 2'd0, 6'd5);
        idle_cycles(1);
        wait_drain();

        // 2: VADD lane wrap, no carry into lane 1
        issue(2'b00, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0002, 16'h0, 2'd0, 6'd9);
        idle_cycles(1);
        wait_drain();

        // 3: VCOMPMOVI into lane 2
        issue(2'b11, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 16'h1234, 2'd2, 6'd17);
        idle_cycles(1);
        wait_drain();

        // 4: VMOVI with 3 downstream stall cycles in DONE
        stall_left = 3;
        issue(2'b10, 64'h0123_4567_89AB_CDEF, 64'h0, 16'h00FF, 2'd0, 6'd33);
        idle_cycles(1);
        wait_drain();
        chk("valid_hold_len", 64'(last_len), 64'(4));

        // 5: async reset in RUN at lane 2 aborts the op
        issue(2'b00, 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 16'h0, 2'd0, 6'd44);
        I_Valid = 1'b0;
        @(negedge I_CLOCK);
        #1;
        @(negedge I_CLOCK);
        #1;
        I_RESETN = 1'b0;
        #1;
        chk("abort_valid", 64'(O_EX_Valid), 64'(0));
        chk("abort_vec", 64'(O_VecDestValue), 64'(0));
        chk("abort_alua", 64'(O_AluA), 64'(0));
        chk("abort_ready", 64'(O_Ready), 64'(1));
        sb.delete();
        @(posedge I_CLOCK);
        @(negedge I_CLOCK);
        #1;
        I_RESETN = 1'b1;
        #1;
        chk("ready_after_reset", 64'(O_Ready), 64'(1));
        idle_cycles(8);

        // 6: back-to-back with I_Valid held high
        issue(2'b01, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 16'h0, 2'd0, 6'd1);
        issue(2'b00, 64'h8000_7FFF_0001_FFFF, 64'h8000_0001_FFFF_0001, 16'h0, 2'd0, 6'd2);
        I_Valid = 1'b0;
        wait_drain();

        // Random ops with random downstream stalls and gaps
        stall_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  16'($urandom), 2'($urandom_range(0, 3)), 6'($urandom));
            idle_cycles($urandom_range(0, 3));
        end
        I_Valid = 1'b0;
        stall_rand = 1'b0;
        wait_drain();
        chk("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
